// File: rtl/toilet_pkg.sv
// Shared constants for the toilet input front-end: channel indices, register
// reset defaults and the debounce state encoding.
package toilet_pkg;

  localparam int N_CH        = 7;
  localparam int CH_PRESENCE = 0;
  localparam int CH_SEAT     = 1;
  localparam int CH_SPRAY    = 2;
  localparam int CH_MODE     = 3;
  localparam int CH_AUTO     = 4;
  localparam int CH_AUTO_DIS = 5;
  localparam int CH_DE_UR    = 6;

  localparam logic RST_SPRAY_EN      = 1'b0;
  localparam logic RST_SPRAY_MODE    = 1'b0;
  localparam logic RST_SP_DR_AUTO_EN = 1'b1;
  localparam logic RST_AUTO_DIS_EN   = 1'b1;
  localparam logic RST_DE_UR         = 1'b0;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } deb_state_t;

endpackage

// File: rtl/input_debounce.sv
// One input channel: 2-FF synchroniser followed by a STABLE/CHECK debouncer.
// press/unpress are combinational pulses in the cycle before level changes.
module input_debounce
  import toilet_pkg::*;
#(
  parameter int DEB_CNT = 20000,
  parameter int DEB_W   = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw,
  output logic       level,
  output logic       press,
  output logic       unpress,
  output deb_state_t state
);

  localparam logic [DEB_W-1:0] LAST = DEB_W'(DEB_CNT - 1);

  logic             sync_q1;
  logic             sync_q2;
  deb_state_t       state_next;
  logic [DEB_W-1:0] cnt;
  logic [DEB_W-1:0] cnt_next;
  logic             level_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      state   <= ST_STABLE;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      state   <= state_next;
      cnt     <= cnt_next;
      level   <= level_next;
    end
  end

  // The first differing sample already counts as 1, so a level is accepted
  // after DEB_CNT consecutive differing synchronised samples.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    level_next = level;
    press      = 1'b0;
    unpress    = 1'b0;
    case (state)
      ST_STABLE: begin
        cnt_next = '0;
        if (sync_q2 != level) begin
          state_next = ST_CHECK;
          cnt_next   = DEB_W'(1);
        end
      end
      ST_CHECK: begin
        if (sync_q2 == level) begin
          state_next = ST_STABLE;
          cnt_next   = '0;
        end else if (cnt == LAST) begin
          state_next = ST_STABLE;
          cnt_next   = '0;
          level_next = sync_q2;
          press      = sync_q2;
          unpress    = ~sync_q2;
        end else begin
          cnt_next = cnt + DEB_W'(1);
        end
      end
      default: begin
        state_next = ST_STABLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/toilet_input_ctrl.sv
// Input conditioning for the toilet controller core: debounced sensor levels
// and button-driven control registers. Optional: TOILET_INPUT_LONG_PRESS_EN.
module toilet_input_ctrl
  import toilet_pkg::*;
#(
  parameter int DEB_CNT  = 20000,
  parameter int DEB_W    = 15,
  parameter int LONG_CNT = 2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic sns_presence,
  input  logic sns_seat,
  input  logic btn_spray,
  input  logic btn_mode,
  input  logic btn_auto,
  input  logic btn_auto_dis,
  input  logic btn_de_ur,
  input  logic count_drying_done,
  input  logic count_dis_done,
  output logic reg_user_en,
  output logic reg_toilet_using,
  output logic reg_spray_en,
  output logic reg_spray_mode,
  output logic reg_sp_dr_auto_en,
  output logic reg_auto_dis_en,
  output logic reg_de_ur
);

  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] lvl;
  logic [N_CH-1:0] prs;
  logic [N_CH-1:0] unp;
  logic [N_CH-1:0] deb_checking;
  logic            spray_clr;
  logic            mode_toggle;
  logic            long_fire;
  logic            unused_sig;

  assign raw[CH_PRESENCE] = sns_presence;
  assign raw[CH_SEAT]     = sns_seat;
  assign raw[CH_SPRAY]    = btn_spray;
  assign raw[CH_MODE]     = btn_mode;
  assign raw[CH_AUTO]     = btn_auto;
  assign raw[CH_AUTO_DIS] = btn_auto_dis;
  assign raw[CH_DE_UR]    = btn_de_ur;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_deb
    input_debounce #(
      .DEB_CNT(DEB_CNT),
      .DEB_W  (DEB_W)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .raw    (raw[ch]),
      .level  (lvl[ch]),
      .press  (prs[ch]),
      .unpress(unp[ch]),
      .state  (deb_checking[ch])
    );
  end

  assign reg_user_en      = lvl[CH_PRESENCE];
  assign reg_toilet_using = lvl[CH_SEAT];

  // Leaving the seat cancels a pending spray just like the drying-done pulse.
  assign spray_clr = count_drying_done | unp[CH_SEAT];

`ifdef TOILET_INPUT_LONG_PRESS_EN
  localparam int LONG_W = (LONG_CNT > 1) ? $clog2(LONG_CNT) : 1;
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CNT - 1);

  logic [LONG_W-1:0] long_cnt;
  logic              long_done;

  always_ff @(posedge clk) begin
    if (reset || !lvl[CH_MODE]) begin
      long_cnt  <= '0;
      long_done <= 1'b0;
    end else if (!long_done) begin
      if (long_cnt == LONG_LAST) long_done <= 1'b1;
      else                       long_cnt  <= long_cnt + LONG_W'(1);
    end
  end

  assign long_fire   = lvl[CH_MODE] & ~long_done & (long_cnt == LONG_LAST);
  assign mode_toggle = unp[CH_MODE] & ~long_done;
  assign unused_sig  = ^{prs, unp, deb_checking};
`else
  assign long_fire   = 1'b0;
  assign mode_toggle = prs[CH_MODE];
  assign unused_sig  = ^{prs, unp, deb_checking, LONG_CNT[0]};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_spray_en      <= RST_SPRAY_EN;
      reg_spray_mode    <= RST_SPRAY_MODE;
      reg_sp_dr_auto_en <= RST_SP_DR_AUTO_EN;
      reg_auto_dis_en   <= RST_AUTO_DIS_EN;
      reg_de_ur         <= RST_DE_UR;
    end else begin
      // A press cancels an active spray and only arms it while seated.
      if (spray_clr)          reg_spray_en <= 1'b0;
      else if (prs[CH_SPRAY]) reg_spray_en <= ~reg_spray_en & reg_toilet_using;

      if (long_fire) begin
        reg_spray_mode    <= RST_SPRAY_MODE;
        reg_sp_dr_auto_en <= RST_SP_DR_AUTO_EN;
        reg_auto_dis_en   <= RST_AUTO_DIS_EN;
      end else begin
        if (mode_toggle)       reg_spray_mode    <= ~reg_spray_mode;
        if (prs[CH_AUTO])      reg_sp_dr_auto_en <= ~reg_sp_dr_auto_en;
        if (prs[CH_AUTO_DIS])  reg_auto_dis_en   <= ~reg_auto_dis_en;
      end

      if (count_dis_done || long_fire) reg_de_ur <= 1'b0;
      else if (prs[CH_DE_UR])          reg_de_ur <= ~reg_de_ur;
    end
  end

endmodule

// File: doc/toilet_input_ctrl.md
Name: toilet_input_ctrl

Overview:
- Front-end conditioning stage that produces every reg_* control level consumed by the toilet controller core.
- Synchronises and debounces raw push-buttons and occupancy sensors, then turns button presses into latched or toggled control registers.
- Clears those registers using the core's count_*_done feedback pulses.
- Runs on the same 1 MHz system clock as the core.

Parameters:
- DEB_CNT, 20000, consecutive stable cycles needed to accept a new input level (20 ms at 1 MHz).
- DEB_W, 15, debounce counter width; must satisfy 2^DEB_W > DEB_CNT.
- LONG_CNT, 2000000, hold cycles for a long press (2 s); used only with LONG_PRESS_EN.

Ports:
- clk  in  1  system clock, 1 MHz
- reset  in  1  synchronous reset, active-high
- sns_presence  in  1  raw user-presence sensor, active-high, asynchronous
- sns_seat  in  1  raw seat-occupied sensor, active-high, asynchronous
- btn_spray  in  1  raw spray request button, active-high
- btn_mode  in  1  raw spray-mode select button
- btn_auto  in  1  raw spray/dry auto-sequence enable button
- btn_auto_dis  in  1  raw auto-discharge enable button
- btn_de_ur  in  1  raw flush-volume select button
- count_drying_done  in  1  one-cycle pulse from core: drying finished
- count_dis_done  in  1  one-cycle pulse from core: discharge finished
- reg_user_en  out  1  debounced presence level
- reg_toilet_using  out  1  debounced seat level
- reg_spray_en  out  1  latched spray request
- reg_spray_mode  out  1  spray mode, 0 = front, 1 = rear
- reg_sp_dr_auto_en  out  1  automatic spray-then-dry enable
- reg_auto_dis_en  out  1  automatic discharge enable
- reg_de_ur  out  1  flush volume, 0 = urination (small), 1 = defecation (large)

Behaviour:
- Every raw input passes through a 2-FF synchroniser, then a debouncer, before any use.
- Debouncer has two states, STABLE and CHECK:
  - STABLE, sync value equal to accepted level: counter held at 0.
  - Sync value differs from accepted level: go to CHECK and count.
  - CHECK, sync value returns to accepted level before count reaches DEB_CNT-1: return to STABLE, counter to 0.
  - Count reaches DEB_CNT-1 with value still different: accepted level updates on the next edge; return to STABLE.
- Press pulse is a one-cycle pulse on the accepted-level 0->1 transition. Total latency from a clean raw edge to the press pulse is 2 + DEB_CNT cycles.
- reg_user_en and reg_toilet_using are the accepted levels of the presence and seat sensors, registered.
- reg_spray_en:
  - Set on a spray press when reg_toilet_using=1; a press while reg_toilet_using=0 is ignored.
  - A press while already set clears it (cancel).
  - Cleared on count_drying_done, or on the reg_toilet_using 1->0 transition.
  - If set and clear conditions occur in the same cycle, clear wins.
- reg_spray_mode, reg_sp_dr_auto_en and reg_auto_dis_en each toggle on their button press.
- reg_de_ur toggles on its button press and is forced to 0 on count_dis_done; count_dis_done wins over a simultaneous press.
- Reset values: all debounced levels 0, all outputs 0 except reg_sp_dr_auto_en=1 and reg_auto_dis_en=1. Counters and synchronisers are cleared.
- Reset asserted mid-debounce: the pending transition is discarded.
- Outputs are updated only on clk edges and are glitch-free, since every output is a flop.

Optional Feature:
- Macro: TOILET_INPUT_LONG_PRESS_EN.
- When defined:
  - A second counter measures how long btn_mode's accepted level stays high.
  - Reaching LONG_CNT restores reg_spray_mode=0, reg_sp_dr_auto_en=1, reg_auto_dis_en=1 and reg_de_ur=0 (factory defaults).
  - The short-press toggle of reg_spray_mode moves from the press edge to the release edge, and is suppressed if the long press fired.
- When undefined: the long-press counter is absent, and mode toggles on the press edge.

Decomposition:
- Shared package toilet_pkg holds:
  - channel index constants (CH_PRESENCE .. CH_DE_UR, N_CH=7);
  - reset-default constants for each register;
  - the debounce state encoding (ST_STABLE, ST_CHECK).
- One sub-module, input_debounce, parameterised by DEB_CNT/DEB_W. It contains the synchroniser and debouncer and outputs the accepted level and press pulse. It is instantiated N_CH times via generate.

Test Plan (sim with DEB_CNT=4, LONG_CNT=16):
- Reset released with all inputs 0 -> all outputs 0 except reg_sp_dr_auto_en=1 and reg_auto_dis_en=1.
- btn_mode bounces 1,0,1 for 1 cycle each, then holds 1 -> exactly one toggle, reg_spray_mode=1, occurring 6 cycles after the final raw rise.
- sns_seat=1 stable, then a btn_spray press -> reg_spray_en=1. Pulse count_drying_done -> 0 the next cycle. Press again while sns_seat=0 -> stays 0.
- reg_spray_en=1, then a second btn_spray press coinciding with count_drying_done -> reg_spray_en=0, with no re-set.
- reg_de_ur toggled to 1, then count_dis_done pulsed in the same cycle as a btn_de_ur press pulse -> reg_de_ur=0.
- Reset asserted during the CHECK state of btn_auto -> no toggle; reg_sp_dr_auto_en=1 after reset. With TOILET_INPUT_LONG_PRESS_EN, a btn_mode hold ≥16 cycles -> defaults restored, no release toggle.
